// File: rtl/serial_twenty_bit_adder_pkg.sv
// Shared constants and state encoding for the multi-cycle serial adder.
// Holds the default geometry, slice-count helpers and the FSM state type.
package serial_twenty_bit_adder_pkg;

  localparam int DEF_WIDTH = 20;
  localparam int DEF_BPC   = 4;
  localparam int SLICES    = DEF_WIDTH / DEF_BPC;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter width, kept at least one bit so a single-slice build still has a counter.
  function automatic int cnt_width(input int slices);
    return (slices > 1) ? $clog2(slices) : 1;
  endfunction

  localparam int CNT_W = cnt_width(SLICES);

endpackage

// File: rtl/serial_twenty_bit_adder_slice_adder.sv
// Ripple-carry slice built from full_adder cells; also reports the carry into
// its MSB so the top level can derive signed overflow on the final slice.
module full_adder (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));
endmodule

module slice_adder #(
  parameter int BITS = 4
) (
  input  logic [BITS-1:0] x,
  input  logic [BITS-1:0] y,
  input  logic            ci,
  output logic [BITS-1:0] s,
  output logic            co,
  output logic            c_msb
);
  logic [BITS:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < BITS; i++) begin : g_fa
    full_adder u_fa (
      .x  (x[i]),
      .y  (y[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  assign co    = c[BITS];
  assign c_msb = c[BITS-1];
endmodule

// File: rtl/serial_twenty_bit_adder.sv
// Multi-cycle adder: sums BITS_PER_CYCLE bits per clock from the LSB slice up,
// with a start/busy/done handshake and results held until the next start.
module serial_twenty_bit_adder
  import serial_twenty_bit_adder_pkg::*;
#(
  parameter int WIDTH          = DEF_WIDTH,
  parameter int BITS_PER_CYCLE = DEF_BPC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);
  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if ((WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_geometry
    $error("BITS_PER_CYCLE must divide WIDTH evenly");
  end

  // Handshake: start is honoured only in IDLE or DONE; busy is high in RUN;
  // done is a one-cycle pulse, and sum/cout/overflow stay valid from done
  // until the next accepted start.
  state_t              state_q;
  logic [CW-1:0]       cnt_q;
  logic                carry_q;
  logic [WIDTH-1:0]    a_q, b_q;
  logic [WIDTH-1:0]    sum_q;
  logic                cout_q, ovf_q, busy_q, done_q;

  logic [BITS_PER_CYCLE-1:0] slice_s;
  logic                      slice_co, slice_cmsb;

  slice_adder #(.BITS(BITS_PER_CYCLE)) u_slice (
    .x     (a_q[cnt_q*BITS_PER_CYCLE +: BITS_PER_CYCLE]),
    .y     (b_q[cnt_q*BITS_PER_CYCLE +: BITS_PER_CYCLE]),
    .ci    (carry_q),
    .s     (slice_s),
    .co    (slice_co),
    .c_msb (slice_cmsb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        RUN: begin
          sum_q[cnt_q*BITS_PER_CYCLE +: BITS_PER_CYCLE] <= slice_s;
          carry_q <= slice_co;
          if (cnt_q == LAST) begin
            // The final slice's internal carry into its MSB is the carry into bit WIDTH-1.
            cout_q  <= slice_co;
            ovf_q   <= slice_cmsb ^ slice_co;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule
